adc_ram_reader: RTL and testbench

Drains the ADC sample RAM filled by the capture path and streams its contents out through the UART transmitter as bytes. On a host `SEND_ADC` command it reads words 0..NWORDS-1 through the RAM read port and splits each sample into two bytes. It hands the bytes to the UART TX over a valid/ready handshake and reports completion on `status`. It sits between the dual-port sample RAM (read port) and the UART TX.

---
 rtl/adc_ram_reader_pkg.sv | 28 ++
 rtl/adc_ram_reader.sv | 99 +++++++++
 tb/tb_adc_ram_reader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_ram_reader_pkg.sv
// Shared host command codes, UART/ADC widths and reader FSM states.
package adc_ram_reader_pkg;

  localparam int UART_WIDTH = 8;
  localparam int ADC_WIDTH  = 12;
  localparam int ADDR       = 9;
  localparam int SAMPLES    = 256;

  // Host command bytes and completion codes
  localparam logic [UART_WIDTH-1:0] STRT_ADC = 8'h01;
  localparam logic [UART_WIDTH-1:0] ADC_RD   = 8'h02;
  localparam logic [UART_WIDTH-1:0] SEND_ADC = 8'h03;
  localparam logic [UART_WIDTH-1:0] ADC_TX   = 8'h04;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    SEND_HI,
    SEND_LO,
    DONE
  } reader_state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_ram_reader.sv
// Drains the ADC sample RAM on a SEND_ADC command and streams each sample
// to the UART TX as a high byte followed by a low byte.
module adc_ram_reader
  import adc_ram_reader_pkg::*;
#(
  parameter int DATA_W = ADC_WIDTH,
  parameter int ADDR_W = ADDR,
  parameter int NWORDS = 2 * SAMPLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [UART_WIDTH-1:0] command,
  output logic                  ram_re,
  output logic [ADDR_W-1:0]     ram_addr,
  input  logic [DATA_W-1:0]     ram_dout,
  output logic [UART_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic [UART_WIDTH-1:0] status
);

  localparam int CNT_W = cnt_width(NWORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

  reader_state_t     state;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] sample;
  logic              prev_match;
  logic              match;
  logic [15:0]       dout_ext;
  logic [15:0]       sample_ext;

  assign match      = (command == SEND_ADC);
  assign dout_ext   = 16'(ram_dout);
  assign sample_ext = 16'(sample);

  // Only a fresh match seen while idle starts a drain; a held command never retriggers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      sample     <= '0;
      prev_match <= 1'b0;
      ram_re     <= 1'b0;
      ram_addr   <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      status     <= '0;
    end else begin
      prev_match <= match;
      ram_re     <= 1'b0;
      case (state)
        IDLE: begin
          if (match && !prev_match) begin
            state    <= RD_REQ;
            count    <= '0;
            ram_re   <= 1'b1;
            ram_addr <= '0;
            busy     <= 1'b1;
            status   <= '0;
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          sample   <= ram_dout;
          tx_data  <= dout_ext[15:8];
          tx_valid <= 1'b1;
          state    <= SEND_HI;
        end
        SEND_HI: begin
          if (tx_ready) begin
            tx_data <= sample_ext[7:0];
            state   <= SEND_LO;
          end
        end
        SEND_LO: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (count == LAST) begin
              state  <= DONE;
              busy   <= 1'b0;
              status <= ADC_TX;
            end else begin
              count    <= count + 1'b1;
              ram_addr <= ADDR_W'(count + 1'b1);
              ram_re   <= 1'b1;
              state    <= RD_REQ;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_ram_reader.sv
// Directed bench for adc_ram_reader: a 4-word RAM model feeds the reader
// and a monitor records every accepted byte and every RAM read.
module tb_adc_ram_reader;
  import adc_ram_reader_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  command;
  logic        ram_re;
  logic [3:0]  ram_addr;
  logic [11:0] ram_dout;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic [7:0]  status;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [11:0] mem [16];
  logic [7:0]  bytes [$];
  logic [3:0]  addrs [$];
  int          reads;
  int          valid_cycles;
  int          stall_errs;
  int          stall_cycles;
  logic        stalled;
  logic [7:0]  stalled_data;
  logic        rand_mode;
  logic        ready_fixed;
  logic [7:0]  exp_bytes [8];

  adc_ram_reader #(
    .DATA_W(12),
    .ADDR_W(4),
    .NWORDS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .command(command),
    .ram_re(ram_re),
    .ram_addr(ram_addr),
    .ram_dout(ram_dout),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM port: data valid the cycle after ram_re
  always @(posedge clk) if (ram_re) ram_dout <= mem[ram_addr];

  always @(negedge clk)
    tx_ready = rand_mode ? ($urandom_range(0, 99) < 30) : ready_fixed;

  always @(posedge clk) begin
    if (tx_valid && tx_ready) bytes.push_back(tx_data);
    if (ram_re) begin
      reads = reads + 1;
      addrs.push_back(ram_addr);
    end
    if (tx_valid) valid_cycles = valid_cycles + 1;
    if (stalled && (!tx_valid || tx_data != stalled_data)) stall_errs = stall_errs + 1;
    if (tx_valid && !tx_ready) stall_cycles = stall_cycles + 1;
    stalled      = rst && tx_valid && !tx_ready;
    stalled_data = tx_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run = tests_run + 1;
    if (observed !== expected) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input int cycles);
    @(negedge clk);
    command = cmd;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic clearMon();
    bytes.delete();
    addrs.delete();
    reads        = 0;
    valid_cycles = 0;
    stall_errs   = 0;
    stall_cycles = 0;
  endtask

  task automatic waitDone(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (status == ADC_TX) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_done"}, 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkBytes(input string tag);
    logic [31:0] obs;
    checkOutput({tag, "_count"}, 32'(bytes.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      obs = (i < bytes.size()) ? 32'(bytes[i]) : 32'hFFFF_FFFF;
      checkOutput($sformatf("%s_b%0d", tag, i), obs, 32'(exp_bytes[i]));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 12'h000;
    mem[0] = 12'hABC;
    mem[1] = 12'h123;
    mem[2] = 12'hFFF;
    mem[3] = 12'h000;
    exp_bytes = '{8'h0A, 8'hBC, 8'h01, 8'h23, 8'h0F, 8'hFF, 8'h00, 8'h00};
    rst = 1'b0;
    command = 8'h00;
    ready_fixed = 1'b1;
    rand_mode = 1'b0;
    tx_ready = 1'b1;
    stalled = 1'b0;
    stalled_data = 8'h00;
    ram_dout = 12'h000;
    clearMon();

    #1;
    checkOutput("rst_ram_re", 32'(ram_re), 32'd0);
    checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_status", 32'(status), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    applyStimulus(8'h00, 2);

    // Free-running drain with exact cycle timing
    clearMon();
    applyStimulus(SEND_ADC, 0);
    @(posedge clk); #1;
    checkOutput("t1_ram_re", 32'(ram_re), 32'd1);
    checkOutput("t1_ram_addr", 32'(ram_addr), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 1) checkOutput("t1_re_drop", 32'(ram_re), 32'd0);
      if (k == 2) checkOutput("t1_first_valid", 32'(tx_valid), 32'd1);
      if (k == 15) checkOutput("t1_status_pre", 32'(status), 32'd0);
      if (k == 15) checkOutput("t1_busy_pre", 32'(busy), 32'd1);
      if (k == 16) checkOutput("t1_status_done", 32'(status), 32'(ADC_TX));
      if (k == 16) checkOutput("t1_busy_done", 32'(busy), 32'd0);
    end
    repeat (100) @(negedge clk);
    checkBytes("t1");
    checkOutput("t1_reads", 32'(reads), 32'd4);
    checkOutput("t1_status_hold", 32'(status), 32'(ADC_TX));

    // Toggle away and back: second identical drain, status cleared on start
    applyStimulus(8'h00, 3);
    clearMon();
    applyStimulus(SEND_ADC, 0);
    @(posedge clk); #1;
    checkOutput("t3_status_clr", 32'(status), 32'd0);
    checkOutput("t3_busy", 32'(busy), 32'd1);
    waitDone("t3");
    checkBytes("t3");

    // Random back-pressure
    applyStimulus(8'h00, 3);
    clearMon();
    rand_mode = 1'b1;
    applyStimulus(SEND_ADC, 0);
    waitDone("t2");
    rand_mode = 1'b0;
    checkBytes("t2");
    checkOutput("t2_stall_errs", 32'(stall_errs), 32'd0);
    checkOutput("t2_had_stalls", 32'(stall_cycles > 0), 32'd1);

    // New SEND_ADC edge mid-drain is ignored
    applyStimulus(8'h00, 3);
    clearMon();
    applyStimulus(SEND_ADC, 4);
    applyStimulus(STRT_ADC, 2);
    applyStimulus(SEND_ADC, 0);
    waitDone("t4");
    repeat (30) @(negedge clk);
    checkBytes("t4");
    checkOutput("t4_reads", 32'(reads), 32'd4);

    // Asynchronous reset after the third accepted byte
    applyStimulus(8'h00, 3);
    clearMon();
    applyStimulus(SEND_ADC, 0);
    for (int i = 0; i < 100 && bytes.size() < 3; i++) begin
      @(posedge clk); #2;
    end
    checkOutput("t5_three_bytes", 32'(bytes.size()), 32'd3);
    checkOutput("t5_valid_pre", 32'(tx_valid), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("t5_valid_rst", 32'(tx_valid), 32'd0);
    checkOutput("t5_busy_rst", 32'(busy), 32'd0);
    checkOutput("t5_status_rst", 32'(status), 32'd0);
    command = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("t5_reads_rst", 32'(reads), 32'd2);
    rst = 1'b1;
    applyStimulus(8'h00, 2);
    clearMon();
    applyStimulus(SEND_ADC, 0);
    waitDone("t5");
    checkOutput("t5_first_addr", (addrs.size() > 0) ? 32'(addrs[0]) : 32'hFFFF_FFFF, 32'd0);
    checkBytes("t5");

    // Non-SEND_ADC commands never start a drain
    clearMon();
    applyStimulus(STRT_ADC, 30);
    applyStimulus(ADC_RD, 30);
    applyStimulus(8'hFF, 30);
    applyStimulus(8'h00, 5);
    checkOutput("t6_reads", 32'(reads), 32'd0);
    checkOutput("t6_valid", 32'(valid_cycles), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
